// File: rtl/mem_responder_if.sv
// Memory port bundle between the CPU (master) and the memory responder (slave).
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        misalign;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  rdata, ready, misalign
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output rdata, ready, misalign
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: latches one access, waits LAT cycles, then completes
// it against a byte-lane word array with alignment checking and read extension.
module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] LAT_CNT = 4'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [3:0]        count_reg;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              sext_reg;
    logic [ADDR_W+1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic              ready_reg;
    logic              misalign_reg;

    logic              accept;
    logic              complete;
    logic              access_err;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic [1:0]        lane_sel;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [3:0][7:0]   rd_word;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       read_ext;
    logic              unused_addr_hi;

    // Address bits above the word index are ignored, so the array wraps.
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    assign accept   = (state_reg == IDLE) && bus.req;
    assign complete = (state_reg == BUSY) && (count_reg == 4'd0);
    assign rd_idx   = bus.addr[ADDR_W+1:2];
    assign wr_idx   = addr_reg[ADDR_W+1:2];
    assign lane_sel = addr_reg[1:0];

    // Alignment check on the latched request; size 11 is always an error.
    always_comb begin
        access_err = 1'b0;
        case (size_reg)
            2'b01:   access_err = lane_sel[0];
            2'b10:   access_err = (lane_sel != 2'b00);
            2'b11:   access_err = 1'b1;
            default: access_err = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data for the latched request.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = wdata_reg;
        case (size_reg)
            2'b00: begin
                lane_be    = 4'b0001 << lane_sel;
                lane_wdata = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                lane_be    = lane_sel[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_reg[15:0]}};
            end
            2'b10: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_reg;
            end
            default: begin
                lane_be    = 4'b0000;
                lane_wdata = wdata_reg;
            end
        endcase
    end

    // One byte-wide array per lane. The read is registered at the accept edge,
    // which is safe because a write can only land at a completion edge and the
    // DONE cycle always separates it from the next accept.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_lane_reg;

            // Lane write at completion; lane read captured when an access is accepted.
            always_ff @(posedge clk) begin
                if (complete && we_reg && !access_err && lane_be[gi]) begin
                    lane_mem[wr_idx] <= lane_wdata[gi*8 +: 8];
                end
                if (accept) begin
                    rd_lane_reg <= lane_mem[rd_idx];
                end
            end

            assign rd_word[gi] = rd_lane_reg;
        end
    endgenerate

    // Lane extraction and sign/zero extension of the read word.
    always_comb begin
        byte_val = rd_word[lane_sel];
        half_val = lane_sel[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
        read_ext = 32'h0000_0000;
        case (size_reg)
            2'b00:   read_ext = sext_reg ? {{24{byte_val[7]}}, byte_val} : {24'h00_0000, byte_val};
            2'b01:   read_ext = sext_reg ? {{16{half_val[15]}}, half_val} : {16'h0000, half_val};
            2'b10:   read_ext = rd_word;
            default: read_ext = 32'h0000_0000;
        endcase
    end

    // Access FSM: latch in IDLE, count down in BUSY, one-cycle ready in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= 4'd0;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            sext_reg     <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0000_0000;
            rdata_reg    <= 32'h0000_0000;
            ready_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        we_reg    <= bus.we;
                        size_reg  <= bus.size;
                        sext_reg  <= bus.sext;
                        addr_reg  <= bus.addr[ADDR_W+1:0];
                        wdata_reg <= bus.wdata;
                        count_reg <= LAT_CNT;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (count_reg == 4'd0) begin
                        rdata_reg    <= (we_reg || access_err) ? 32'h0000_0000 : read_ext;
                        misalign_reg <= access_err;
                        ready_reg    <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                DONE: begin
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata    = rdata_reg;
    assign bus.ready    = ready_reg;
    assign bus.misalign = misalign_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LAT=2 instance for the access tests and
// one LAT=0 instance for back-to-back acceptance and address aliasing.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        use0;

    int total = 0;
    int bad   = 0;
    int n;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    always #5 clk = ~clk;

    mem_responder_if m2 ();
    mem_responder_if m0 ();

    assign m2.req   = req & ~use0;
    assign m2.we    = we;
    assign m2.size  = size;
    assign m2.sext  = sext;
    assign m2.addr  = addr;
    assign m2.wdata = wdata;

    assign m0.req   = req & use0;
    assign m0.we    = we;
    assign m0.size  = size;
    assign m0.sext  = sext;
    assign m0.addr  = addr;
    assign m0.wdata = wdata;

    mem_responder #(.ADDR_W(8), .LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (m2.slave)
    );

    mem_responder #(.ADDR_W(8), .LAT(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (m0.slave)
    );

    function automatic logic cur_ready();
        return use0 ? m0.ready : m2.ready;
    endfunction

    function automatic logic [31:0] cur_rdata();
        return use0 ? m0.rdata : m2.rdata;
    endfunction

    function automatic logic cur_mis();
        return use0 ? m0.misalign : m2.misalign;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access from a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic access(input string tag, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis);
        int cnt;
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = ~w; size = ~sz; sext = ~sx; addr = ~a; wdata = ~wd;
        cnt = 1;
        while (!cur_ready() && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, " latency"}, cnt, use0 ? 32'd2 : 32'd4);
        check({tag, " rdata"}, cur_rdata(), exp_rd);
        check({tag, " misalign"}, {31'd0, cur_mis()}, {31'd0, exp_mis});
        @(negedge clk);
        check({tag, " pulse_end"}, {31'd0, cur_ready()}, 32'd0);
        $display("access %s we=%0b size=%0d addr=%h rdata=%h mis=%0b",
                 tag, w, sz, a, cur_rdata(), cur_mis());
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'h0; wdata = 32'h0; use0 = 1'b0;
        b2b_addr = '{32'h0000_0400, 32'h0000_0004, 32'h0000_0404, 32'h0000_0000};
        b2b_exp  = '{32'h1111_1111, 32'h2222_2222, 32'h2222_2222, 32'h1111_1111};

        repeat (3) @(negedge clk);
        check("reset rdata", m2.rdata, 32'h0);
        check("reset ready", {31'd0, m2.ready}, 32'd0);
        check("reset misalign", {31'd0, m2.misalign}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic word and byte traffic on the LAT=2 instance.
        access("wr_w_10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access("rd_w_10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
        access("wr_b_11",   1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAA_AA7F, 32'h0, 1'b0);
        access("rd_b_11s",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         32'h0000_007F, 1'b0);
        access("rd_w_10b",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_7FEF, 1'b0);
        access("rd_b_13s",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'hFFFF_FFDE, 1'b0);
        access("rd_b_13z",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'h0000_00DE, 1'b0);

        // Halfword extension.
        access("wr_w_8001", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_1234, 32'h0, 1'b0);
        access("rd_h_12s",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         32'hFFFF_8001, 1'b0);
        access("rd_h_12z",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'h0000_8001, 1'b0);
        access("rd_h_10s",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'h0000_1234, 1'b0);

        // Misaligned and reserved-size accesses.
        access("wr_h_13",   1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access("rd_w_keep", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8001_1234, 1'b0);
        access("rd_w_0e",   1'b0, 2'b10, 1'b0, 32'h0E, 32'h0,         32'h0, 1'b1);
        access("rd_w_again",1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8001_1234, 1'b0);
        access("rd_sz3",    1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0, 1'b1);

        // Partial-lane writes preserve the other lanes.
        access("wr_h_12",   1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_BEEF, 32'h0, 1'b0);
        access("rd_w_beef", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hBEEF_1234, 1'b0);
        access("wr_b_13",   1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5655, 32'h0, 1'b0);
        access("rd_w_55",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h55EF_1234, 1'b0);
        access("rd_b_12z",  1'b0, 2'b00, 1'b0, 32'h12, 32'h0,         32'h0000_00EF, 1'b0);

        // Reset while a write is in BUSY: no commit, outputs clear immediately.
        access("wr_w_20",   1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0);
        access("rd_w_20",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'hCAFE_F00D, 1'b0);
        req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        #1;
        check("abort rdata", m2.rdata, 32'h0);
        check("abort ready", {31'd0, m2.ready}, 32'd0);
        check("abort misalign", {31'd0, m2.misalign}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort no_pulse", {31'd0, m2.ready}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        $display("reset during busy write to 0x20 applied");
        access("rd_w_20_old", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);

        // LAT=0 instance: seed two words, then hold req high across accesses.
        use0 = 1'b1;
        access("l0_wr_000", 1'b1, 2'b10, 1'b0, 32'h000, 32'h1111_1111, 32'h0, 1'b0);
        access("l0_wr_004", 1'b1, 2'b10, 1'b0, 32'h004, 32'h2222_2222, 32'h0, 1'b0);
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = b2b_addr[0]; wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == ((k == 0) ? 1 : 2)) begin
                    addr = 32'h0000_00F0;
                    size = 2'b00;
                end
            end while (!m0.ready && n < 20);
            check("b2b spacing", n, (k == 0) ? 32'd2 : 32'd3);
            check("b2b rdata", m0.rdata, b2b_exp[k]);
            check("b2b misalign", {31'd0, m0.misalign}, 32'd0);
            $display("b2b k=%0d addr=%h gap=%0d rdata=%h", k, b2b_addr[k], n, m0.rdata);
            if (k < 3) begin
                addr = b2b_addr[k + 1];
                size = 2'b10;
            end else begin
                req = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b pulse_end", {31'd0, m0.ready}, 32'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU's data/instruction memory port. It accepts one access per request, holds the request fields for a programmable number of wait cycles, and then completes it against an internal word array. It supports byte, halfword and word reads and writes, with sign or zero extension on reads. Misaligned and reserved-size accesses complete as error responses and never modify storage.

Parameters:
ADDR_W, 8, word-index width; storage holds 2**ADDR_W 32-bit words; byte address bits [ADDR_W+1:2] select the word, and higher bits are ignored (address wraps).
LAT, 2, wait cycles inserted before completion; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  1  access request; sampled only in IDLE.
we  input  1  1 = write, 0 = read.
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
sext  input  1  reads only: 1 = sign-extend, 0 = zero-extend.
addr  input  32  byte address.
wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
rdata  output  32  read result, extended to 32 bits.
ready  output  1  single-cycle completion pulse.
misalign  output  1  error flag; valid only while ready=1.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, rdata=0, ready=0, misalign=0. Storage contents are not cleared. Reset during BUSY aborts the access; a pending write is not committed.
- FSM states are IDLE, BUSY, DONE. All outputs are registered.
- IDLE: on an edge with req=1, latch we/size/sext/addr/wdata, load count=LAT, go to BUSY. With req=0, stay in IDLE.
- BUSY: if count==0, perform the access, update rdata/misalign, set ready=1, go to DONE; otherwise count decrements.
- Latency: for an access accepted at edge E0, ready is high in the cycle after edge E0+LAT+1. With LAT=0, that is the cycle after E0+1.
- DONE: lasts exactly 1 cycle. ready returns to 0 and state returns to IDLE at the next edge. req is not sampled in DONE.
- Back-to-back: if req is still high in the following IDLE cycle, a new access is accepted. Minimum spacing between accepts is LAT+3 cycles.
- Input changes while in BUSY or DONE are ignored; only the latched fields are used.
- Alignment rules:
  - Error if size=01 and addr[0]=1.
  - Error if size=10 and addr[1:0]!=0.
  - Error if size=11, for any address.
  - On error: misalign=1, rdata=0, storage unchanged.
- Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0], and 3 selects [31:24]. A halfword at addr[1]=1 occupies bits [31:16].
- Reads extract the selected lane, then sign- or zero-extend it per the latched sext. For word reads, sext is ignored. On a write completion, rdata=0.
- Writes update only the selected byte/halfword lanes of the word; other lanes are preserved. The write lands at the same edge ready rises, so a read accepted afterwards returns the new data.
- rdata and misalign hold their values after DONE until the next completion or reset.

Test Plan:
- Reset, then word write 0xDEADBEEF to addr 0x10 (LAT=2), then word read of 0x10 -> ready pulses exactly 1 cycle, 3 cycles after each accept edge; read returns rdata=0xDEADBEEF, misalign=0.
- Byte write 0x7F to 0x11, then byte read of 0x11 with sext=1 -> rdata=0x0000007F. Word read of 0x10 -> 0xDEAD7FEF.
- Halfword read of 0x12 after word 0x8001xxxx is stored at 0x10: sext=1 gives 0xFFFF8001; sext=0 gives 0x00008001.
- Misaligned cases:
  - Halfword write to 0x13 -> misalign=1, rdata=0, and a word read of 0x10 is unchanged.
  - Word read of 0x0E -> misalign=1.
  - size=11 at 0x10 -> misalign=1.
- Assert reset during BUSY of a word write of 0x12345678 to 0x20 -> outputs go to 0 immediately, no ready pulse, and a later read of 0x20 returns the old contents.
- Hold req=1 continuously with LAT=0, alternating addresses -> accepts are spaced 3 cycles apart; requests are not sampled in DONE or BUSY; address 0x400 aliases to 0x000 when ADDR_W=8.
